// File: rtl/mlab_ram_pkg.sv
// Shared types and helpers for the multi-port async-read MLAB RAM.
package mlab_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Number of byte lanes in a word; word widths are whole bytes.
  function automatic int byte_count(input int data_width);
    return data_width / 8;
  endfunction

  // Even-parity bit for one byte: makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] byte_val);
    return ^byte_val;
  endfunction

endpackage

// File: rtl/mlab_ram_init_seq.sv
// Init/clear sequencer: sweeps INIT_VALUE through every entry after reset or
// on clr, generates busy/wr_ready/init_done, and muxes the single write port
// between the sweep and the user.
module mlab_ram_init_seq
  import mlab_ram_pkg::*;
#(
  parameter int                        DATA_WIDTH = 16,
  parameter int                        ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH/8-1:0]        mem_be,
  output logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           busy,
  output logic                           wr_ready,
  output logic                           init_done
);

  localparam int NB = byte_count(DATA_WIDTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_addr_q, sweep_addr_d;
  logic                    busy_q, busy_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    init_done_q, init_done_d;
  logic                    sweep_last;

  // The terminal address is detected directly, so the counter never wraps.
  assign sweep_last = (sweep_addr_q == {ADDR_WIDTH{1'b1}});

  // Next-state logic; clr always restarts the sweep from address 0.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    init_done_d  = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        if (clr) begin
          sweep_addr_d = '0;
        end else if (sweep_last) begin
          state_d      = ST_IDLE;
          sweep_addr_d = '0;
          init_done_d  = 1'b1;
        end else begin
          sweep_addr_d = sweep_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        sweep_addr_d = '0;
        if (clr) state_d = ST_SWEEP;
      end
      default: begin
        state_d      = ST_SWEEP;
        sweep_addr_d = '0;
      end
    endcase
    busy_d     = (state_d == ST_SWEEP);
    wr_ready_d = (state_d == ST_IDLE);
  end

  // State and registered status outputs; reset starts a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SWEEP;
      sweep_addr_q <= '0;
      busy_q       <= 1'b1;
      wr_ready_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      busy_q       <= busy_d;
      wr_ready_q   <= wr_ready_d;
      init_done_q  <= init_done_d;
    end
  end

  // Write-port mux: the sweep owns the port while busy, user writes otherwise.
  always_comb begin
    if (state_q == ST_SWEEP) begin
      mem_we   = 1'b1;
      mem_addr = sweep_addr_q;
      mem_be   = {NB{1'b1}};
      mem_data = INIT_VALUE;
    end else begin
      mem_we   = wr_en && wr_ready_q;
      mem_addr = wr_addr;
      mem_be   = wr_be;
      mem_data = wr_data;
    end
  end

  assign busy      = busy_q;
  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/mlab_async_ram_mp.sv
// Multi-port async-read MLAB/LUT-RAM: one byte-enabled synchronous write
// port, NUM_RD combinational read ports, hardware init sweep.
// Optional per-byte parity is enabled by defining MLAB_RAM_PARITY_EN.
module mlab_async_ram_mp
  import mlab_ram_pkg::*;
#(
  parameter int                        DATA_WIDTH = 16,
  parameter int                        ADDR_WIDTH = 6,
  parameter int                        NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
`ifdef MLAB_RAM_PARITY_EN
  input  logic                           par_inj,
  output logic [NUM_RD-1:0]              rd_perr,
`endif
  output logic                           busy,
  output logic                           init_done
);

  localparam int NB    = byte_count(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NB-1:0]           mem_be;
  logic [DATA_WIDTH-1:0]   mem_data;

  // Storage has no reset so it still maps onto MLAB/LUT-RAM.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  mlab_ram_init_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_data  (mem_data),
    .busy      (busy),
    .wr_ready  (wr_ready),
    .init_done (init_done)
  );

  // Byte-enabled synchronous write into the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
  end

  // Combinational read ports, forced to zero while the sweep is running.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!busy) rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

`ifdef MLAB_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          inj_bit;

  // Injection only applies to user writes, never to the sweep.
  assign inj_bit = par_inj && !busy;

  // Parity bits are written alongside their byte lanes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) par_mem[mem_addr][b] <= even_parity(mem_data[8*b +: 8]) ^ inj_bit;
      end
    end
  end

  // Per-port parity check, held low while busy.
  always_comb begin
    rd_perr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (!busy && (even_parity(mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]][8*b +: 8]) !=
                      par_mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]][b]))
          rd_perr[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlab_async_ram_mp.sv
// Directed self-checking bench for mlab_async_ram_mp (default parameters:
// 16-bit words, 64 entries, 2 read ports, INIT_VALUE 0).
module tb_mlab_async_ram_mp;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        init_done;
`ifdef MLAB_RAM_PARITY_EN
  logic        par_inj;
  logic [1:0]  rd_perr;
`endif

  int testCount = 0;
  int failCount = 0;

  mlab_async_ram_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`ifdef MLAB_RAM_PARITY_EN
    .par_inj   (par_inj),
    .rd_perr   (rd_perr),
`endif
    .busy      (busy),
    .init_done (init_done)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write cycle, optionally with clr in the same cycle
  task automatic applyStimulus(input logic [5:0] addr, input logic [15:0] data,
                               input logic [1:0] be, input logic clrVal);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    clr     = clrVal;
    tick();
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Follow a sweep to completion: edge count until busy drops, init_done
  // pulses, and busy-time violations (nonzero read data or wr_ready high).
  // With dropWrites set, a write to address 2 is attempted every busy cycle.
  task automatic waitSweep(input bit dropWrites, output int cycles, output int pulses, output int busyViol);
    cycles = 0;
    pulses = 0;
    busyViol = 0;
    wr_addr = 6'd2;
    wr_data = 16'hDEAD;
    wr_be   = 2'b11;
    for (int i = 1; i <= 200; i++) begin
      wr_en = dropWrites && busy;
      tick();
      if (init_done) pulses++;
      if (busy && (rd_data !== 32'h0 || wr_ready !== 1'b0)) busyViol++;
      if (!busy && cycles == 0) begin
        cycles = i;
        wr_en = 1'b0;
      end
      if (cycles != 0 && i >= cycles + 2) break;
    end
    wr_en = 1'b0;
  endtask

  // Count entries on both ports that differ from the given value
  task automatic scanAll(input logic [15:0] expVal, output int bad);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      rd_addr = {6'(a), 6'(a)};
      #1;
      if (rd_data[15:0] !== expVal || rd_data[31:16] !== expVal) bad++;
    end
  endtask

  int cyc, pls, viol, bad;

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_addr = '0;
`ifdef MLAB_RAM_PARITY_EN
    par_inj = 1'b0;
`endif

    // Reset state
    #22;
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset_init_done", 32'(init_done), 32'd0);

    // Release reset away from the edge and follow the power-up sweep
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_addr = {6'd7, 6'd2};
    waitSweep(1'b0, cyc, pls, viol);
    checkOutput("por_sweep_cycles", 32'(cyc), 32'd64);
    checkOutput("por_init_done_pulses", 32'(pls), 32'd1);
    checkOutput("por_busy_violations", 32'(viol), 32'd0);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);
    scanAll(16'h0000, bad);
    checkOutput("por_all_zero", 32'(bad), 32'd0);

    // Full-word write then partial byte write
    applyStimulus(6'd5, 16'hA55A, 2'b11, 1'b0);
    rd_addr = {6'd0, 6'd5};
    #1;
    checkOutput("wr_full_word", 32'(rd_data[15:0]), 32'h0000A55A);
    applyStimulus(6'd5, 16'h1234, 2'b01, 1'b0);
    #1;
    checkOutput("wr_low_byte", 32'(rd_data[15:0]), 32'h0000A534);
    applyStimulus(6'd5, 16'h1234, 2'b10, 1'b0);
    #1;
    checkOutput("wr_high_byte", 32'(rd_data[15:0]), 32'h00001234);

    // wr_be = 0 is a no-op
    applyStimulus(6'd5, 16'hFFFF, 2'b00, 1'b0);
    #1;
    checkOutput("wr_be_zero_noop", 32'(rd_data[15:0]), 32'h00001234);

    // Same-cycle read of the address being written returns old data
    rd_addr = {6'd9, 6'd9};
    wr_en   = 1'b1;
    wr_addr = 6'd9;
    wr_data = 16'hBEEF;
    wr_be   = 2'b11;
    #1;
    checkOutput("same_cycle_old", rd_data, 32'h00000000);
    tick();
    wr_en = 1'b0;
    checkOutput("after_edge_both_ports", rd_data, 32'hBEEFBEEF);

    // Fill the whole memory with 0x1000+addr
    for (int a = 0; a < 64; a++) applyStimulus(6'(a), 16'h1000 + 16'(a), 2'b11, 1'b0);
    rd_addr = {6'd63, 6'd20};
    #1;
    checkOutput("fill_readback", rd_data, 32'h103F1014);

    // clr together with an accepted write, then attempted writes during sweep
    rd_addr = {6'd7, 6'd2};
    applyStimulus(6'd7, 16'h7777, 2'b11, 1'b1);
    checkOutput("clr_busy", 32'(busy), 32'd1);
    checkOutput("clr_wr_ready", 32'(wr_ready), 32'd0);
    waitSweep(1'b1, cyc, pls, viol);
    checkOutput("clr_sweep_cycles", 32'(cyc), 32'd64);
    checkOutput("clr_init_done_pulses", 32'(pls), 32'd1);
    checkOutput("clr_busy_violations", 32'(viol), 32'd0);
    scanAll(16'h0000, bad);
    checkOutput("clr_all_init", 32'(bad), 32'd0);

    // clr mid-sweep restarts from address 0: a full 64 cycles after the second clr
    applyStimulus(6'd11, 16'h5555, 2'b11, 1'b0);
    pulseClr();
    for (int i = 0; i < 10; i++) tick();
    pulseClr();
    waitSweep(1'b0, cyc, pls, viol);
    checkOutput("clr_restart_cycles", 32'(cyc), 32'd64);
    checkOutput("clr_restart_pulses", 32'(pls), 32'd1);

    // Reset at sweep address 30 restarts the sweep after release
    pulseClr();
    for (int i = 0; i < 30; i++) tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    waitSweep(1'b0, cyc, pls, viol);
    checkOutput("midreset_sweep_cycles", 32'(cyc), 32'd64);
    checkOutput("midreset_pulses", 32'(pls), 32'd1);
    checkOutput("post_sweep_init_done_low", 32'(init_done), 32'd0);

`ifdef MLAB_RAM_PARITY_EN
    // Injected parity error is seen on port 0, clean port 1 stays quiet
    par_inj = 1'b1;
    applyStimulus(6'd3, 16'h00FF, 2'b11, 1'b0);
    par_inj = 1'b0;
    rd_addr = {6'd4, 6'd3};
    #1;
    checkOutput("perr_injected", 32'(rd_perr), 32'd1);
    applyStimulus(6'd3, 16'h00FF, 2'b11, 1'b0);
    #1;
    checkOutput("perr_cleared", 32'(rd_perr), 32'd0);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      rd_addr = {6'(a), 6'(a)};
      #1;
      if (rd_perr !== 2'b00) bad++;
    end
    checkOutput("perr_clean_all", 32'(bad), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
